serial_mag_compare: RTL and testbench



---
 rtl/cmp_pkg.sv | 36 +++
 rtl/serial_mag_compare_if.sv | 33 +++
 rtl/nibble_cmp_slice.sv | 17 +
 rtl/serial_mag_compare.sv | 99 +++++++++
 tb/tb_serial_mag_compare.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
//   state_t  : controller states (IDLE, RUN)
//   casc_t   : cascade / result triple {gt, lt, eq}
//   CASC_EQ  : cascade seed for a new comparison ("equal so far")
//   nib_cmp  : one 4-bit compare stage with cascade inputs
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } casc_t;

  localparam casc_t CASC_EQ = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};

  // A difference in this nibble overrides whatever the lower nibbles
  // decided. Equal nibbles pass the lower-order verdict through unchanged.
  function automatic casc_t nib_cmp(input logic [3:0] a4,
                                    input logic [3:0] b4,
                                    input casc_t      casc_in);
    casc_t r;
    r = casc_in;
    if (a4 > b4) begin
      r = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
    end else if (a4 < b4) begin
      r = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_compare_if.sv
// Start/done handshake bundle between the controlling logic and the comparator.
//   start   : request a comparison; only sampled while busy is low
//   a, b    : operands, only need to be stable on the accepting edge
//   busy    : high while nibbles are being processed
//   done    : one-cycle pulse when gt/lt/eq have just been loaded
//   gt/lt/eq: registered result, held until the next done or reset
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// comparator is idle (busy=0). start while busy=1 is ignored, not queued.
// Exactly one done pulse follows each accepted request unless reset
// intervenes. Holding start high gives one comparison after another.
interface serial_mag_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, a, b,
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/nibble_cmp_slice.sv
// Purely combinational 4-bit magnitude compare stage with cascade inputs,
// equivalent to one package of a cascaded comparator chain.
//   a4, b4   : nibble operands
//   casc_in  : verdict from the lower-order nibbles
//   casc_out : verdict including this nibble
module nibble_cmp_slice
  import cmp_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  casc_t      casc_in,
  output casc_t      casc_out
);

  assign casc_out = nib_cmp(a4, b4, casc_in);

endmodule

// File: rtl/serial_mag_compare.sv
// Iterative wide-operand magnitude comparator. One nibble_cmp_slice is fed
// one nibble per clock, LSB nibble first, with the previous registered
// verdict fed back as its cascade input. A WIDTH-bit compare takes
// NIB = WIDTH/4 cycles from the accepting edge to the done pulse.
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   bus       : slave side of serial_mag_compare_if (start, a, b, busy,
//               done, gt, lt, eq)
//   state_dbg : current controller state
// WIDTH must be a multiple of 4 and at least 4.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_mag_compare_if.slave  bus,
  output state_t               state_dbg
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx;
  casc_t            casc;
  casc_t            casc_nxt;
  casc_t            res;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;

  // Select nibble idx of the captured operands; {idx, 2'b00} is idx*4.
  always_comb begin
    a_nib = 4'(a_q >> {idx, 2'b00});
    b_nib = 4'(b_q >> {idx, 2'b00});
  end

  nibble_cmp_slice u_slice (
    .a4       (a_nib),
    .b4       (b_nib),
    .casc_in  (casc),
    .casc_out (casc_nxt)
  );

  // busy drops on the last-nibble edge, so a start held through the done
  // cycle is accepted on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res    <= '0;
      idx    <= '0;
      casc   <= CASC_EQ;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            idx    <= '0;
            casc   <= CASC_EQ;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          casc <= casc_nxt;
          if (idx == IDX_LAST) begin
            res    <= casc_nxt;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.gt    = res.gt;
  assign bus.lt    = res.lt;
  assign bus.eq    = res.eq;
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench for serial_mag_compare: directed cases on a WIDTH=16 instance and
// randomized sweeps on WIDTH=4, 8 and 32 instances against a plain
// arithmetic reference (A>B, A<B, A==B).
module tb_serial_mag_compare;
  import cmp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- WIDTH=16 instance ----------------
  serial_mag_compare_if #(.WIDTH(16)) bus16 ();
  state_t st16;

  serial_mag_compare #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus16),
    .state_dbg (st16)
  );

  function automatic logic [2:0] ref_cmp16(input logic [15:0] x, input logic [15:0] y);
    return {x > y, x < y, x == y};
  endfunction

  // scoreboard of expected {gt,lt,eq} results
  logic [2:0] exp_q[$];

  // Start one compare from idle and follow the fixed timeline edge by edge.
  // Operands are inverted right after acceptance to show they are ignored.
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v);
    logic [2:0] exp_res;
    exp_res = ref_cmp16(ta, tb_v);
    bus16.a = ta;
    bus16.b = tb_v;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.a = ~ta;
    bus16.b = ~tb_v;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, bus16.busy, 1);
      check({tag, "_nodone"}, bus16.done, 0);
      @(posedge clk); #1;
    end
    check({tag, "_busy_end"}, bus16.busy, 0);
    check({tag, "_done"}, bus16.done, 1);
    check({tag, "_res"}, {bus16.gt, bus16.lt, bus16.eq}, exp_res);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, bus16.done, 0);
    check({tag, "_hold"}, {bus16.gt, bus16.lt, bus16.eq}, exp_res);
  endtask

  // ---------------- sweep instances (WIDTH=4, 8, 32) ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 32;
    localparam int N = W / 4;

    serial_mag_compare_if #(.WIDTH(W)) sbus ();
    state_t sst;
    logic   srst = 1'b1;
    bit     fin  = 1'b0;

    serial_mag_compare #(.WIDTH(W)) sdut (
      .clk       (clk),
      .rst       (srst),
      .bus       (sbus),
      .state_dbg (sst)
    );

    initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [2:0]   exp_res;
      int lat;
      int mode;
      int pos;
      sbus.start = 1'b0;
      sbus.a = '0;
      sbus.b = '0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      for (int it = 0; it < 60; it++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        mode = $urandom_range(0, 3);
        if (mode == 0) begin
          rb = ra;
        end else if (mode == 1) begin
          pos = $urandom_range(0, N - 1);
          rb = ra;
          rb[pos*4 +: 4] = 4'($urandom);
        end
        exp_res = {ra > rb, ra < rb, ra == rb};
        sbus.a = ra;
        sbus.b = rb;
        sbus.start = 1'b1;
        @(posedge clk); #1;
        sbus.start = 1'b0;
        sbus.a = W'($urandom);
        sbus.b = W'($urandom);
        check($sformatf("w%0d_busy", W), sbus.busy, 1);
        lat = 0;
        while (!sbus.done && lat < 2 * N + 4) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("w%0d_latency", W), lat, N);
        check($sformatf("w%0d_res a=%0h b=%0h", W, ra, rb),
              {sbus.gt, sbus.lt, sbus.eq}, exp_res);
        check($sformatf("w%0d_onehot", W), $countones({sbus.gt, sbus.lt, sbus.eq}), 1);
      end
      fin = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  ndone;
    bit  drop_next;
    bit  all_fin;
    logic [2:0] exp_res;

    bus16.start = 1'b0;
    bus16.a = '0;
    bus16.b = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus16.busy, 0);
    check("rst_done", bus16.done, 0);
    check("rst_res", {bus16.gt, bus16.lt, bus16.eq}, 0);
    check("rst_state", st16, IDLE);
    rst = 1'b0;

    // idle, start=0 for 10 cycles
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("idle_busy", bus16.busy, 0);
      check("idle_done", bus16.done, 0);
      check("idle_res", {bus16.gt, bus16.lt, bus16.eq}, 0);
    end

    run16("eq_1234", 16'h1234, 16'h1234);
    run16("gt_8000", 16'h8000, 16'h7FFF);
    run16("lt_00ff", 16'h00FF, 16'h0100);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] xa;
      logic [15:0] xb;
      xa = 16'($urandom);
      xb = (k % 2 == 0) ? xa : 16'($urandom);
      run16($sformatf("rnd16_%0d", k), xa, xb);
    end

    // back-to-back with start held high
    exp_q.push_back(ref_cmp16(16'hFFFF, 16'h0000));
    exp_q.push_back(ref_cmp16(16'h0000, 16'hFFFF));
    bus16.a = 16'hFFFF;
    bus16.b = 16'h0000;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.a = 16'h0000;
    bus16.b = 16'hFFFF;
    ndone = 0;
    drop_next = 1'b0;
    for (int c = 0; c < 30 && ndone < 2; c++) begin
      @(posedge clk); #1;
      if (drop_next) begin
        bus16.start = 1'b0;
        bus16.a = 16'($urandom);
        bus16.b = 16'($urandom);
        drop_next = 1'b0;
      end
      if (bus16.done) begin
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        check("b2b_res", {bus16.gt, bus16.lt, bus16.eq}, exp_res);
        ndone++;
        if (ndone == 1) drop_next = 1'b1;
      end
    end
    bus16.start = 1'b0;
    check("b2b_count", ndone, 2);
    check("b2b_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // reset at the 2nd RUN edge
    bus16.a = 16'hF000;
    bus16.b = 16'h0000;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", bus16.busy, 0);
    check("abort_done", bus16.done, 0);
    check("abort_res", {bus16.gt, bus16.lt, bus16.eq}, 0);
    check("abort_state", st16, IDLE);
    // reset wins over start on the same edge
    bus16.start = 1'b1;
    @(posedge clk); #1;
    check("rst_prio_busy", bus16.busy, 0);
    check("rst_prio_state", st16, IDLE);
    bus16.start = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", bus16.done, 0);
      check("abort_cleared", {bus16.gt, bus16.lt, bus16.eq}, 0);
    end
    run16("eq_0001", 16'h0001, 16'h0001);

    // wait for the sweeps, bounded
    all_fin = 1'b0;
    for (int c = 0; c < 5000 && !all_fin; c++) begin
      @(posedge clk); #1;
      all_fin = g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin;
    end
    check("sweeps_finished", all_fin, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
